// File: rtl/bcd_display_scan.sv
// Binary to BCD conversion by serial double-dabble, then time-multiplexed onto one
// 4-bit BCD bus with active-low, one-cold digit enables for the board display.
//   state    | meaning
//   S_IDLE   | waiting for load; display regs hold the last committed value
//   S_SHIFT  | BIN_W double-dabble iterations, one input bit per clock
//   S_COMMIT | copy BCD result and overflow flag into the display regs
module bcd_display_scan #(
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIN_W-1:0]  bin_in,
  input  logic              load,
  output logic              busy,
  output logic              ovf,
  output logic [3:0]        digit_bcd,
  output logic [DIGITS-1:0] anodos
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_t;

  state_t state, state_nxt;
  logic   accept, shifting, commit;

  logic [CNT_W-1:0]  bit_cnt;
  logic [BIN_W-1:0]  bin_sh;
  logic [BCD_W-1:0]  bcd_sh;
  logic              ovf_pend;
  logic [BCD_W-1:0]  disp, disp_nxt;

  logic [REF_W-1:0]  ref_cnt;
  logic              ref_tc;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [3:0]        dig_sel;
  logic [DIGITS-1:0] an_nxt, blank;

  // One double-dabble iteration: +3 on every nibble >= 5, then shift in the next binary bit.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b, input logic lsb);
    logic [BCD_W-1:0] a;
    a = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) a[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return {a[BCD_W-2:0], lsb};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    shifting  = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (load) begin
          accept    = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shifting = 1'b1;
        if (bit_cnt == '0) state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        commit    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      bin_sh   <= '0;
      bcd_sh   <= '0;
      ovf_pend <= 1'b0;
    end else if (accept) begin
      bit_cnt  <= CNT_W'(BIN_W - 1);
      bin_sh   <= (bin_in > MAX_VAL) ? MAX_VAL : bin_in;
      bcd_sh   <= '0;
      ovf_pend <= (bin_in > MAX_VAL);
    end else if (shifting) begin
      bit_cnt <= bit_cnt - CNT_W'(1);
      bcd_sh  <= dd_step(bcd_sh, bin_sh[BIN_W-1]);
      bin_sh  <= {bin_sh[BIN_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp <= '0;
      ovf  <= 1'b0;
    end else if (commit) begin
      disp <= bcd_sh;
      ovf  <= ovf_pend;
    end
  end

  // Scan outputs are built from next-cycle values so a committed digit shows with busy low.
  assign disp_nxt = commit ? bcd_sh : disp;

  always_comb begin
    ref_tc  = (ref_cnt == REF_W'(REFRESH_DIV - 1));
    idx_nxt = idx;
    if (ref_tc) idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
  end

  always_comb begin
    logic nz_hi;
    nz_hi   = 1'b0;
    blank   = '0;
    dig_sel = 4'd0;
    an_nxt  = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz_hi    = nz_hi | (disp_nxt[4*i +: 4] != 4'd0);
      blank[i] = BLANK_LZ && (i != 0) && !nz_hi;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        dig_sel   = disp_nxt[4*i +: 4];
        an_nxt[i] = blank[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt   <= '0;
      idx       <= '0;
      digit_bcd <= 4'd0;
      anodos    <= ~DIGITS'(1);
    end else begin
      ref_cnt   <= ref_tc ? '0 : ref_cnt + REF_W'(1);
      idx       <= idx_nxt;
      digit_bcd <= dig_sel;
      anodos    <= an_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: accepted loads push the expected display value,
// a negedge monitor pops on each busy fall and checks busy/ovf/scan outputs every cycle.
module tb_bcd_display_scan;
  localparam int ND   = 4;
  localparam int BW   = 14;
  localparam int RD   = 4;
  localparam int MAXV = 9999;
  localparam int CONV = BW + 1;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic          load   = 1'b0;
  logic [BW-1:0] bin_in = '0;
  logic          busy, ovf;
  logic [3:0]    digit_bcd;
  logic [ND-1:0] anodos;

  bcd_display_scan #(
    .DIGITS(ND), .BIN_W(BW), .REFRESH_DIV(RD), .BLANK_LZ(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load),
    .busy(busy), .ovf(ovf), .digit_bcd(digit_bcd), .anodos(anodos)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0, errors = 0;
  int   ncyc = 0, acc_n = 0, shown_val = 0;
  bit   shown_ovf = 1'b0, acc_valid = 1'b0, prev_busy = 1'b0;

  // clock edges since reset release; the scan position is a pure function of this
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  function automatic int pow10(input int k);
    int p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    return p;
  endfunction

  function automatic bit model_busy(input int m);
    return acc_valid && (m >= acc_n) && (m < acc_n + CONV);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  initial begin
    int   e_idx, e_dig, e_an;
    bit   blanked;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && prev_busy && !busy) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL commit: conversion ended with no accepted load pending (cycle %0d)", ncyc);
        end else begin
          e = sb_q.pop_front();
          shown_val = e.val;
          shown_ovf = e.ovf;
        end
      end
      prev_busy = busy;
      e_idx   = (ncyc / RD) % ND;
      blanked = (e_idx > 0) && (shown_val < pow10(e_idx));
      e_dig   = (shown_val / pow10(e_idx)) % 10;
      e_an    = blanked ? 15 : (15 ^ (1 << e_idx));
      chk("busy", int'(busy), int'(model_busy(ncyc)));
      chk("ovf", int'(ovf), int'(shown_ovf));
      chk("digit_bcd", int'(digit_bcd), e_dig);
      chk("anodos", int'(anodos), e_an);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    exp_t e;
    bit   acc;
    acc    = !model_busy(ncyc);
    bin_in = BW'(v);
    load   = 1'b1;
    if (acc) begin
      e.val = (v > MAXV) ? MAXV : v;
      e.ovf = (v > MAXV);
      sb_q.push_back(e);
      acc_n     = ncyc + 1;
      acc_valid = 1'b1;
    end
    step();
    load = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    sb_q.delete();
    acc_valid = 1'b0;
    shown_val = 0;
    shown_ovf = 1'b0;
    repeat (hold) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * CONV && model_busy(ncyc); i++) step();
  endtask

  initial begin
    int v;
    #1;
    do_reset(5);
    repeat (6) step();

    do_load(1234);
    repeat (CONV + 40) step();

    do_load(12000);
    repeat (CONV + 36) step();
    do_load(5);
    repeat (CONV + 36) step();

    do_load(7);
    repeat (CONV + 24) step();
    do_load(0);
    repeat (CONV + 24) step();

    do_load(1234);
    repeat (4) step();
    do_load(4321);
    wait_idle();
    do_load(4321);
    repeat (CONV + 36) step();

    do_load(9876);
    repeat (7) step();
    do_reset(3);
    repeat (40) step();

    for (int k = 0; k < 40; k++) begin
      v = int'($urandom_range(0, 16383));
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 120));
      do_load(v);
      repeat ($urandom_range(0, 24)) step();
    end
    wait_idle();
    repeat (24) step();

    chk("scoreboard_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
